// File: rtl/word_buffer.sv
// word_buffer: working store of gesture pattern codes with a frame-synchronous
// display copy.
//
// Words are appended with a valid/ready handshake. Backspace removes the last
// word, and clear erases everything. The display registers are loaded from the
// working store only on i_frame_start, so a frame never shows a half-updated
// buffer.
//
// Optional feature: define WORD_BUFFER_SCROLL_EN to accept writes when the
// buffer is full. The oldest word is then discarded, the rest shift down, and
// the new word lands in the last entry.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_valid, i_code   producer handshake and the code to append
//   o_ready           buffer accepts i_code this cycle (combinational)
//   i_bksp, i_clear   single-cycle edit pulses
//   i_frame_start     display timing pulse; the display loads on this edge
//   o_word_cnt        displayed word count
//   o_pattern_num     displayed codes, entry k at [CODE_W*k +: CODE_W]
//   o_full, o_empty   working-count status
//
// state    | meaning
// S_ACCEPT | normal operation: append / backspace / clear request
// S_CLEAR  | zeroing one working entry per cycle, inputs ignored
module word_buffer #(
  parameter int DEPTH  = 32,
  parameter int CODE_W = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [CODE_W-1:0]         i_code,
  output logic                      o_ready,
  input  logic                      i_bksp,
  input  logic                      i_clear,
  input  logic                      i_frame_start,
  output logic [5:0]                o_word_cnt,
  output logic [DEPTH*CODE_W-1:0]   o_pattern_num,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0]       DEPTH_C  = 6'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_ACCEPT, S_CLEAR} state_t;

  state_t            state_q;
  logic [5:0]        count_q;
  logic [5:0]        disp_cnt_q;
  logic [IDX_W-1:0]  clr_idx_q;
  logic [CODE_W-1:0] mem_q  [DEPTH];
  logic [CODE_W-1:0] disp_q [DEPTH];

  logic              full;
  logic              empty;
  logic              can_take;
  logic              xfer;
  logic [5:0]        cnt_dec;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  bk_idx;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == 6'd0);

`ifdef WORD_BUFFER_SCROLL_EN
  assign can_take = 1'b1;
`else
  assign can_take = !full;
`endif

  // Clear and backspace win arbitration. Dropping ready here tells the
  // producer its word was not taken, so it keeps holding it.
  assign o_ready = (state_q == S_ACCEPT) && can_take && !i_clear && !i_bksp;
  assign xfer    = i_valid && o_ready;

  assign cnt_dec = count_q - 6'd1;
  assign wr_idx  = count_q[IDX_W-1:0];
  assign bk_idx  = cnt_dec[IDX_W-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_ACCEPT;
      count_q    <= 6'd0;
      disp_cnt_q <= 6'd0;
      clr_idx_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k]  <= '0;
        disp_q[k] <= '0;
      end
    end else begin
      // The display samples pre-edge working values, so edits made on this
      // same edge show up at the next frame.
      if (i_frame_start) begin
        disp_cnt_q <= count_q;
        for (int k = 0; k < DEPTH; k++) disp_q[k] <= mem_q[k];
      end

      case (state_q)
        S_ACCEPT: begin
          if (i_clear) begin
            count_q   <= 6'd0;
            clr_idx_q <= '0;
            state_q   <= S_CLEAR;
          end else if (i_bksp) begin
            if (!empty) begin
              mem_q[bk_idx] <= '0;
              count_q       <= cnt_dec;
            end
          end else if (xfer) begin
            if (!full) begin
              mem_q[wr_idx] <= i_code;
              count_q       <= count_q + 6'd1;
            end
`ifdef WORD_BUFFER_SCROLL_EN
            else begin
              for (int k = 0; k < DEPTH - 1; k++) mem_q[k] <= mem_q[k+1];
              mem_q[DEPTH-1] <= i_code;
            end
`endif
          end
        end
        S_CLEAR: begin
          mem_q[clr_idx_q] <= '0;
          if (clr_idx_q == LAST_IDX) begin
            clr_idx_q <= '0;
            state_q   <= S_ACCEPT;
          end else begin
            clr_idx_q <= clr_idx_q + IDX_W'(1);
          end
        end
        default: state_q <= S_ACCEPT;
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_pack
    assign o_pattern_num[CODE_W*k +: CODE_W] = disp_q[k];
  end

  assign o_word_cnt = disp_cnt_q;
  assign o_full     = full;
  assign o_empty    = empty;

endmodule

// File: tb/tb_word_buffer.sv
// Testbench for word_buffer.
// The driver keeps a reference model made of an array of words, a count and a
// clear countdown. For every driven cycle it pushes the expected visible
// outputs into a queue, and a monitor pops and compares them mid-cycle.
// A handful of directed scenario checks are added on top of the scoreboard.
module tb_word_buffer;

  localparam int DEPTH  = 32;
  localparam int CODE_W = 8;
`ifdef WORD_BUFFER_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    i_rst = 1'b1;
  logic                    i_valid = 1'b0;
  logic [CODE_W-1:0]       i_code = '0;
  logic                    i_bksp = 1'b0;
  logic                    i_clear = 1'b0;
  logic                    i_frame_start = 1'b0;
  logic                    o_ready;
  logic [5:0]              o_word_cnt;
  logic [DEPTH*CODE_W-1:0] o_pattern_num;
  logic                    o_full;
  logic                    o_empty;

  word_buffer #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .i_code        (i_code),
    .o_ready       (o_ready),
    .i_bksp        (i_bksp),
    .i_clear       (i_clear),
    .i_frame_start (i_frame_start),
    .o_word_cnt    (o_word_cnt),
    .o_pattern_num (o_pattern_num),
    .o_full        (o_full),
    .o_empty       (o_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                    ready;
    logic                    full;
    logic                    empty;
    logic [5:0]              cnt;
    logic [DEPTH*CODE_W-1:0] pat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model
  logic [CODE_W-1:0] ref_mem  [DEPTH];
  logic [CODE_W-1:0] disp_mem [DEPTH];
  int                ref_cnt;
  int                disp_cnt;
  int                clr_left;

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin
      ref_mem[k]  = '0;
      disp_mem[k] = '0;
    end
    ref_cnt  = 0;
    disp_cnt = 0;
    clr_left = 0;
  endtask

  // One clock cycle. Inputs are applied just after the falling edge, the
  // expected outputs for the middle of this cycle are queued, and then the
  // model advances by the rising edge that follows.
  task automatic cycle(input logic v, input logic [CODE_W-1:0] c,
                       input logic b, input logic cl, input logic f,
                       input logic r);
    exp_t e;
    logic rdy;
    @(negedge clk);
    i_valid       = v;
    i_code        = c;
    i_bksp        = b;
    i_clear       = cl;
    i_frame_start = f;
    if (!r) i_rst = 1'b0;
    if (r) model_reset();
    rdy = (clr_left == 0) && !cl && !b && ((ref_cnt < DEPTH) || SCROLL);
    e.ready = rdy;
    e.full  = (ref_cnt == DEPTH);
    e.empty = (ref_cnt == 0);
    e.cnt   = 6'(disp_cnt);
    for (int k = 0; k < DEPTH; k++) e.pat[k*CODE_W +: CODE_W] = disp_mem[k];
    exp_q.push_back(e);
    if (r) begin
      #1 i_rst = 1'b1;
    end else begin
      if (f) begin
        for (int k = 0; k < DEPTH; k++) disp_mem[k] = ref_mem[k];
        disp_cnt = ref_cnt;
      end
      if (clr_left > 0) begin
        ref_mem[DEPTH - clr_left] = '0;
        clr_left--;
      end else if (cl) begin
        ref_cnt  = 0;
        clr_left = DEPTH;
      end else if (b) begin
        if (ref_cnt > 0) begin
          ref_cnt--;
          ref_mem[ref_cnt] = '0;
        end
      end else if (v && rdy) begin
        if (ref_cnt < DEPTH) begin
          ref_mem[ref_cnt] = c;
          ref_cnt++;
        end else begin
          for (int k = 0; k < DEPTH - 1; k++) ref_mem[k] = ref_mem[k+1];
          ref_mem[DEPTH-1] = c;
        end
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [CODE_W-1:0] c);
    cycle(1'b1, c, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Monitor: compares the DUT with the queued expectation mid-cycle.
  initial begin
    exp_t e;
    int   cyc = 0;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (o_ready !== e.ready || o_full !== e.full || o_empty !== e.empty ||
            o_word_cnt !== e.cnt || o_pattern_num !== e.pat) begin
          n_fail++;
          $display("FAIL status cyc %0d: got rdy=%b full=%b empty=%b cnt=%0d pat=%h expected rdy=%b full=%b empty=%b cnt=%0d pat=%h",
                   cyc, o_ready, o_full, o_empty, o_word_cnt, o_pattern_num,
                   e.ready, e.full, e.empty, e.cnt, e.pat);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt;
    int r;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    #4;
    chk("reset_ready", 64'(o_ready), 64'd1);
    chk("reset_empty", 64'(o_empty), 64'd1);

    // Two words, then a frame start
    wr(8'd2);
    wr(8'd3);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #4;
    chk("two_words_cnt", 64'(o_word_cnt), 64'd2);
    chk("two_words_e0", 64'(o_pattern_num[7:0]), 64'd2);
    chk("two_words_e1", 64'(o_pattern_num[15:8]), 64'd3);
    chk("two_words_empty", 64'(o_empty), 64'd0);

    // A write in the same cycle as a frame start waits for the next frame
    cycle(1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #4;
    chk("same_frame_cnt", 64'(o_word_cnt), 64'd2);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #4;
    chk("next_frame_cnt", 64'(o_word_cnt), 64'd3);
    chk("next_frame_e2", 64'(o_pattern_num[23:16]), 64'd5);

    // Fill to capacity, then keep pushing code 7
    for (int i = 0; i < DEPTH - 3; i++) wr(8'(10 + i));
    for (int i = 0; i < 3; i++) wr(8'h7);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #4;
    chk("full_cnt", 64'(o_word_cnt), 64'd32);
    chk("full_flag", 64'(o_full), 64'd1);

    // Backspace down to 4 words, then clear
    for (int i = 0; i < DEPTH - 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    low_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      #4;
      if (o_ready) break;
      low_cnt++;
    end
    chk("clear_ready_low_cycles", 64'(low_cnt), 64'd32);
    chk("clear_empty", 64'(o_empty), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #4;
    chk("clear_disp_cnt", 64'(o_word_cnt), 64'd0);
    chk("clear_disp_zero", 64'(o_pattern_num == '0), 64'd1);

    // Backspace on an empty buffer; backspace beats a same-cycle write
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    #4;
    chk("bksp_empty", 64'(o_empty), 64'd1);
    wr(8'd21);
    wr(8'd22);
    wr(8'd23);
    cycle(1'b1, 8'd24, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #4;
    chk("bksp_vs_write_cnt", 64'(o_word_cnt), 64'd2);

    // Reset in the middle of a clear
    wr(8'd31);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) idle();
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    #4;
    chk("rst_mid_clear_ready", 64'(o_ready), 64'd1);
    chk("rst_mid_clear_cnt", 64'(o_word_cnt), 64'd0);
    chk("rst_mid_clear_empty", 64'(o_empty), 64'd1);
    chk("rst_mid_clear_full", 64'(o_full), 64'd0);
    chk("rst_mid_clear_pat", 64'(o_pattern_num == '0), 64'd1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic v, b, cl, f;
      r  = int'($urandom_range(0, 99));
      v  = ($urandom_range(0, 99) < 75);
      b  = (r < 5);
      cl = (r == 99);
      f  = ($urandom_range(0, 99) < 20);
      cycle(v, 8'($urandom), b, cl, f, 1'b0);
    end

    idle();
    idle();
    @(negedge clk);
    #5;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/word_buffer.md
WORD_BUFFER -- requirements
Module: word_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the maximum number of stored words.
REQ-002 The block SHALL have parameter CODE_W, default 8, meaning the width of one pattern code.
REQ-003 The block SHALL have port i_clk, input, 1 bit, the clock; i_rst is asynchronous and active-high.
REQ-004 The block SHALL have port i_rst, input, 1 bit, the asynchronous active-high reset.
REQ-005 The block SHALL have port i_valid, input, 1 bit, meaning i_code holds a recognised gesture code.
REQ-006 The block SHALL have port i_code, input, CODE_W bits, the pattern code to append.
REQ-007 The block SHALL have port o_ready, output, 1 bit, meaning the buffer accepts i_code this cycle.
REQ-008 The block SHALL have port i_bksp, input, 1 bit, a single-cycle pulse that removes the last word.
REQ-009 The block SHALL have port i_clear, input, 1 bit, a single-cycle pulse that erases all words.
REQ-010 The block SHALL have port i_frame_start, input, 1 bit, a single-cycle pulse from display timing at the vertical frame start.
REQ-011 The block SHALL have port o_word_cnt, output, 6 bits, the displayed word count, 0..DEPTH.
REQ-012 The block SHALL have port o_pattern_num, output, DEPTH*CODE_W bits, the displayed codes; entry k is at bits [CODE_W*k+CODE_W-1 : CODE_W*k].
REQ-013 The block SHALL have ports o_full and o_empty, outputs, 1 bit each, reflecting the working count (count==DEPTH and count==0 respectively).

Function
REQ-014 The FSM SHALL have states S_ACCEPT and S_CLEAR; reset enters S_ACCEPT.
REQ-015 A transfer SHALL occur on a clock edge where i_valid && o_ready; only then is i_code written to working entry[count] and count incremented.
REQ-016 o_ready SHALL be asserted combinationally in S_ACCEPT when !o_full, and deasserted in S_CLEAR.
REQ-017 i_valid held with o_ready low SHALL cause no state change; the producer holds i_code until transfer.
REQ-018 i_bksp in S_ACCEPT with count>0 SHALL zero entry[count-1] and decrement count; with count==0 it SHALL be a no-op.
REQ-019 i_clear in S_ACCEPT SHALL set count to 0 at that edge, enter S_CLEAR, and zero one entry per cycle (index 0..DEPTH-1), returning to S_ACCEPT after exactly DEPTH cycles.
REQ-020 In S_CLEAR, i_clear, i_bksp and i_valid SHALL be ignored.
REQ-021 Same-cycle priority SHALL be i_clear > i_bksp > transfer; a lower-priority event losing arbitration is dropped, and o_ready SHALL be low in any cycle where i_clear or i_bksp is high.
REQ-022 On an edge where i_frame_start=1, display registers (o_word_cnt, o_pattern_num) SHALL load the working values that were present before that edge; otherwise they hold.
REQ-023 A word accepted in the same cycle as i_frame_start SHALL appear only at the next frame start; display is never torn mid-frame.
REQ-024 Counts SHALL be unsigned, 6 bits; count never exceeds DEPTH and never underflows.

Reset
REQ-025 On i_rst, all working and display entries SHALL be 0, count 0, o_word_cnt 0, o_empty 1, o_full 0, o_ready 1, and the clear index 0.
REQ-026 Reset asserted mid-clear SHALL abort the clear immediately and return to S_ACCEPT.

Configuration
REQ-027 With macro WORD_BUFFER_SCROLL_EN defined, o_ready SHALL stay high when full, and a transfer at count==DEPTH SHALL shift entries down by one (entry0 discarded), write i_code to entry[DEPTH-1] and keep count at DEPTH, all in one cycle.
REQ-028 Without WORD_BUFFER_SCROLL_EN, writes SHALL be refused when full (o_ready=0), as in REQ-016.

Verification
REQ-029 Reset, write codes 2 then 3, pulse i_frame_start -> o_word_cnt=2, entry0=8'd2, entry1=8'd3, o_empty=0.
REQ-030 Write 5 with i_frame_start in the same cycle -> display unchanged that frame; after the next frame start o_word_cnt=3, entry2=8'd5.
REQ-031 Fill to 32 words, hold i_valid with code 8'h7 -> no scroll: o_ready=0, count stays 32; with WORD_BUFFER_SCROLL_EN: entry31=8'h7, entry0 = old entry1.
REQ-032 Pulse i_clear with 4 words -> o_ready low for exactly 32 cycles, o_empty=1, all entries 0 after the next frame start.
REQ-033 i_bksp with count 0 -> count stays 0; i_bksp together with i_valid at count 3 -> count 2, code dropped.
REQ-034 Assert i_rst during cycle 10 of a clear -> S_ACCEPT, o_ready=1 on the first cycle after reset release, all outputs at reset values.
